miter_sweep_ctrl: RTL and testbench
===================================

# miter_sweep_ctrl

Sequential stimulus-and-compare controller that sits directly upstream of a combinational miter netlist. It drives every primary-input pattern exhaustively into the circuit and waits a programmable settle time. It then compares the implementation outputs against the golden outputs and reports the first failing pattern, its per-output difference mask, and the total mismatch count. It turns a purely combinational equivalence miter into a self-checking block that can be run in simulation or on an FPGA.

## Interface

Parameters:
- N_IN, default 3: number of primary inputs driven; the sweep covers 2^N_IN patterns (range 1..16).
- N_OUT, default 2: number of compared outputs (range 1..32).
- SETTLE, default 1: cycles `pi` is held stable before sampling (range 1..255).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; honoured only in IDLE or DONE.
- stop_on_first  in  1  sampled with `start`; when 1, the sweep ends at the first mismatching pattern.
- pi  out  N_IN  pattern driven to the circuit inputs; `pi[0]` goes to the first declared input.
- po_impl  in  N_OUT  outputs of the circuit under test.
- po_ref  in  N_OUT  golden outputs for the same `pi`.
- busy  out  1  high while a sweep is running.
- done  out  1  level; high from sweep end until the next `start` or `rst`.
- mismatch  out  1  at least one pattern differed in the current or last sweep.
- fail_pattern  out  N_IN  `pi` value of the first mismatching pattern; 0 if none.
- fail_mask  out  N_OUT  `po_impl ^ po_ref` at the first mismatch; 0 if none.
- mismatch_count  out  N_IN+1  number of mismatching patterns; holds values up to 2^N_IN with no saturation needed.

## Operation

The controller has four states: IDLE, SETTLE, COMPARE, DONE.

- IDLE: `pi`=0, `busy`=0, `done`=0.
  - `start`=1 → SETTLE.
  - On that edge: pattern counter = 0, settle counter = SETTLE-1, `mismatch`, `fail_pattern`, `fail_mask` and `mismatch_count` are cleared, `stop_on_first` is latched, and `busy`=1.
- SETTLE: `pi` = pattern counter and is held stable.
  - The settle counter decrements each cycle.
  - When it reads 0, go to COMPARE on the next edge.
- COMPARE (one cycle): diff = `po_impl ^ po_ref`, taken combinationally and registered on the exiting edge.
  - If diff≠0:
    - `mismatch_count` increments.
    - If `mismatch` was 0, capture `fail_pattern` = pattern counter and `fail_mask` = diff, and set `mismatch`=1.
  - If diff≠0 and latched `stop_on_first`=1 → DONE.
  - Else if pattern counter = 2^N_IN-1 → DONE.
  - Otherwise: pattern counter increments, settle counter reloads SETTLE-1, → SETTLE.
- DONE: `busy`=0, `done`=1.
  - Result outputs hold.
  - `pi` holds the last driven pattern.
  - `start`=1 → restart exactly as from IDLE, with `done` cleared on the same edge.
- Boundary behaviour:
  - `start` while `busy`=1 is ignored.
  - `stop_on_first` changes mid-sweep are ignored.
  - The pattern counter never wraps, because the sweep ends at the all-ones pattern.
  - Results reflect only the most recent sweep.

## Timing

- Reset (`rst`=1 at an edge, in any state, including mid-sweep): state IDLE, `pi`=0, `busy`=0, `done`=0, `mismatch`=0, `fail_pattern`=0, `fail_mask`=0, `mismatch_count`=0. Reset overrides `start` on the same edge.
- `busy` rises on the edge that samples `start`.
- Each pattern occupies SETTLE+1 cycles: SETTLE cycles in SETTLE, then 1 in COMPARE.
  - `pi` changes only on the edge leaving COMPARE.
  - `pi` is therefore stable for SETTLE+1 cycles before it is sampled.
- Full sweep with no early stop: `busy` is high for 2^N_IN·(SETTLE+1) cycles.
  - `done` rises on the edge after the final COMPARE.
  - Defaults give 16 cycles.
- Early stop on pattern k: `done` rises (k+1)·(SETTLE+1) cycles after the `start` edge.
- Result outputs update on the COMPARE exit edge and are valid whenever `done`=1.

## Test plan

- Equivalent circuits: `po_impl`=`po_ref` for all patterns; defaults; `start` pulse → `busy` high 16 cycles, then `done`=1, `mismatch`=0, `mismatch_count`=0, `fail_pattern`=0, `fail_mask`=0, `pi`=7.
- Single fault: `po_impl` differs from `po_ref` only in output bit 1 at `pi`=5; `stop_on_first`=0 → `mismatch`=1, `fail_pattern`=5, `fail_mask`=2'b10, `mismatch_count`=1, `done` after 16 cycles.
- Early stop: differences at `pi`=3 (mask 2'b01) and `pi`=6 (mask 2'b11); `stop_on_first`=1 → `done` 8 cycles after start, `fail_pattern`=3, `fail_mask`=2'b01, `mismatch_count`=1. Rerun with `stop_on_first`=0 → `mismatch_count`=2, `fail_pattern`=3, `fail_mask`=2'b01.
- Settle timing: SETTLE=3; golden model whose `po_ref` follows `pi` with 2-cycle latency; `po_impl` also follows with 2-cycle latency → no mismatch, `busy` 32 cycles. Repeat with a 4-cycle latency on `po_impl` → `mismatch`=1.
- Reset mid-sweep: assert `rst` during pattern 4 → next cycle all outputs 0 and state IDLE. A new `start` then sweeps from `pi`=0.
- Start while busy: pulse `start` at cycle 5 of a sweep → ignored, sweep length unchanged. `start` in DONE → results cleared and a new sweep runs.

Source files
------------

// File: rtl/miter_sweep_ctrl.sv
// Exhaustive stimulus-and-compare controller for a combinational miter: sweeps every
// input pattern, waits a settle time, and records the first failure plus a mismatch count.
module miter_sweep_ctrl #(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 2,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop_on_first,
    output logic [N_IN-1:0]   pi,
    input  logic [N_OUT-1:0]  po_impl,
    input  logic [N_OUT-1:0]  po_ref,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [N_IN-1:0]   fail_pattern,
    output logic [N_OUT-1:0]  fail_mask,
    output logic [N_IN:0]     mismatch_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_COMPARE,
        S_DONE
    } state_t;

    localparam logic [7:0]      SETTLE_LOAD = 8'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST_PAT    = '1;

    state_t            state_reg;
    logic [7:0]        settle_reg;
    logic              stop_reg;
    logic [N_IN-1:0]   pat_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              mismatch_reg;
    logic [N_IN-1:0]   fail_pattern_reg;
    logic [N_OUT-1:0]  fail_mask_reg;
    logic [N_IN:0]     count_reg;

    logic [N_OUT-1:0]  diff;
    logic              any_diff;

    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_diff
            assign diff[gi] = po_impl[gi] ^ po_ref[gi];
        end
    endgenerate

    assign any_diff = |diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            settle_reg       <= '0;
            stop_reg         <= 1'b0;
            pat_reg          <= '0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            mismatch_reg     <= 1'b0;
            fail_pattern_reg <= '0;
            fail_mask_reg    <= '0;
            count_reg        <= '0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_reg        <= S_SETTLE;
                        settle_reg       <= SETTLE_LOAD;
                        stop_reg         <= stop_on_first;
                        pat_reg          <= '0;
                        busy_reg         <= 1'b1;
                        done_reg         <= 1'b0;
                        mismatch_reg     <= 1'b0;
                        fail_pattern_reg <= '0;
                        fail_mask_reg    <= '0;
                        count_reg        <= '0;
                    end
                end
                S_SETTLE: begin
                    if (settle_reg == 8'd0) begin
                        state_reg <= S_COMPARE;
                    end else begin
                        settle_reg <= settle_reg - 1'b1;
                    end
                end
                S_COMPARE: begin
                    if (any_diff) begin
                        count_reg <= count_reg + 1'b1;
                        if (!mismatch_reg) begin
                            mismatch_reg     <= 1'b1;
                            fail_pattern_reg <= pat_reg;
                            fail_mask_reg    <= diff;
                        end
                    end
                    // The sweep ends at the all-ones pattern, so pat_reg never wraps.
                    if ((any_diff && stop_reg) || (pat_reg == LAST_PAT)) begin
                        state_reg <= S_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg  <= S_SETTLE;
                        settle_reg <= SETTLE_LOAD;
                        pat_reg    <= pat_reg + 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign pi             = pat_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign mismatch       = mismatch_reg;
    assign fail_pattern   = fail_pattern_reg;
    assign fail_mask      = fail_mask_reg;
    assign mismatch_count = count_reg;

endmodule

// File: tb/tb_miter_sweep_ctrl.sv
// Scoreboard bench: two controllers (SETTLE=1 with a fault-injected circuit, SETTLE=3 with
// latency-delayed circuits); expected sweep results are queued at start and checked at done.
module tb_miter_sweep_ctrl;

    typedef struct {
        logic       mis;
        logic [2:0] fp;
        logic [1:0] fm;
        logic [3:0] cnt;
        int         busy;
        logic [2:0] last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start_a = 1'b0, stop_a = 1'b0, start_b = 1'b0, stop_b = 1'b0;
    logic [2:0] pi_a, pi_b, fp_a, fp_b;
    logic [1:0] impl_a, ref_a, impl_b, ref_b, fm_a, fm_b;
    logic busy_a, done_a, mis_a, busy_b, done_b, mis_b;
    logic [3:0] cnt_a, cnt_b;

    logic [1:0] fault_a [0:7] = '{default: 2'b00};
    logic       lat4 = 1'b0;
    logic [2:0] hist [1:4];
    logic [2:0] last_pi_b = 3'd0;

    exp_t q_a[$];
    exp_t q_b[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [1:0] ref_fn(input logic [2:0] x);
        return {x[2] ^ x[0], x[1] | x[0]};
    endfunction

    // Circuit A: golden function, implementation XORed with a per-pattern fault mask.
    assign ref_a  = ref_fn(pi_a);
    assign impl_a = ref_a ^ fault_a[pi_a];

    // Circuit B: both sides see pi through a delay line (2 cycles golden, 2 or 4 impl).
    always @(posedge clk) begin
        hist[1] <= pi_b;
        hist[2] <= hist[1];
        hist[3] <= hist[2];
        hist[4] <= hist[3];
    end
    assign ref_b  = ref_fn(hist[2]);
    assign impl_b = ref_fn(lat4 ? hist[4] : hist[2]);

    miter_sweep_ctrl #(.N_IN(3), .N_OUT(2), .SETTLE(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stop_on_first(stop_a), .pi(pi_a),
        .po_impl(impl_a), .po_ref(ref_a), .busy(busy_a), .done(done_a), .mismatch(mis_a),
        .fail_pattern(fp_a), .fail_mask(fm_a), .mismatch_count(cnt_a)
    );

    miter_sweep_ctrl #(.N_IN(3), .N_OUT(2), .SETTLE(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stop_on_first(stop_b), .pi(pi_b),
        .po_impl(impl_b), .po_ref(ref_b), .busy(busy_b), .done(done_b), .mismatch(mis_b),
        .fail_pattern(fp_b), .fail_mask(fm_b), .mismatch_count(cnt_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk every pattern in order, count differing ones, stop early if asked.
    function automatic exp_t model(input logic [1:0] d [0:7], input bit stop, input int settle);
        exp_t e;
        e.mis = 1'b0; e.fp = 3'd0; e.fm = 2'd0; e.cnt = 4'd0; e.last = 3'd7;
        for (int p = 0; p < 8; p++) begin
            if (d[p] != 2'b00) begin
                e.cnt = e.cnt + 4'd1;
                if (!e.mis) begin
                    e.mis = 1'b1;
                    e.fp  = 3'(p);
                    e.fm  = d[p];
                end
                if (stop) begin
                    e.last = 3'(p);
                    break;
                end
            end
        end
        e.busy = (int'(e.last) + 1) * (settle + 1);
        return e;
    endfunction

    task automatic compare_result(input string tag, input exp_t e, input logic mis,
                                  input logic [2:0] fp, input logic [1:0] fm,
                                  input logic [3:0] cnt, input int bc, input logic [2:0] pi);
        $display("sweep %s: mismatch=%0d fail_pattern=%0d fail_mask=%0d count=%0d busy_cycles=%0d pi=%0d",
                 tag, mis, fp, fm, cnt, bc, pi);
        check({tag, "_mismatch"},     32'(mis), 32'(e.mis));
        check({tag, "_fail_pattern"}, 32'(fp),  32'(e.fp));
        check({tag, "_fail_mask"},    32'(fm),  32'(e.fm));
        check({tag, "_count"},        32'(cnt), 32'(e.cnt));
        check({tag, "_busy_cycles"},  32'(bc),  32'(e.busy));
        check({tag, "_final_pi"},     32'(pi),  32'(e.last));
    endtask

    initial begin : mon_a
        int bc;
        logic pd;
        bc = 0;
        pd = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_a) bc++;
            if (!busy_a && !done_a) bc = 0;
            if (done_a && !pd) begin
                if (q_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL A_unexpected_done: done rose with no sweep pending");
                end else begin
                    exp_t e;
                    e = q_a.pop_front();
                    compare_result("A", e, mis_a, fp_a, fm_a, cnt_a, bc, pi_a);
                end
                bc = 0;
            end
            pd = done_a;
        end
    end

    initial begin : mon_b
        int bc;
        logic pd;
        bc = 0;
        pd = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_b) bc++;
            if (!busy_b && !done_b) bc = 0;
            if (done_b && !pd) begin
                if (q_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL B_unexpected_done: done rose with no sweep pending");
                end else begin
                    exp_t e;
                    e = q_b.pop_front();
                    compare_result("B", e, mis_b, fp_b, fm_b, cnt_b, bc, pi_b);
                end
                bc = 0;
            end
            pd = done_b;
        end
    end

    task automatic wait_done(input bit which, input string tag);
        int i;
        i = 0;
        while (!(which ? done_b : done_a) && i < 400) begin
            @(negedge clk);
            i++;
        end
        if (!(which ? done_b : done_a)) begin
            checks++; errors++;
            $display("FAIL %s_timeout: done got 0 required 1 within 400 cycles", tag);
        end
    endtask

    task automatic run_a(input logic [1:0] f [0:7], input bit stop, input int poke);
        exp_t e;
        fault_a = f;
        e = model(f, stop, 1);
        q_a.push_back(e);
        @(negedge clk); start_a = 1'b1; stop_a = stop;
        @(negedge clk); start_a = 1'b0; stop_a = !stop;
        check("A_busy_after_start", 32'(busy_a), 1);
        check("A_done_cleared",     32'(done_a), 0);
        check("A_count_cleared",    32'(cnt_a),  0);
        check("A_mismatch_cleared", 32'(mis_a),  0);
        check("A_pi_first",         32'(pi_a),   0);
        if (poke > 0) begin
            repeat (poke) @(negedge clk);
            start_a = 1'b1;
            @(negedge clk); start_a = 1'b0;
        end
        wait_done(1'b0, "A");
        repeat (2) @(negedge clk);
    endtask

    task automatic run_b(input bit l4, input bit stop);
        logic [1:0] d [0:7];
        exp_t e;
        lat4 = l4;
        // With SETTLE=3, a 4-cycle-late implementation compares the previous pattern's value.
        for (int p = 0; p < 8; p++)
            d[p] = l4 ? (ref_fn(p == 0 ? last_pi_b : 3'(p - 1)) ^ ref_fn(3'(p))) : 2'b00;
        e = model(d, stop, 3);
        q_b.push_back(e);
        last_pi_b = e.last;
        @(negedge clk); start_b = 1'b1; stop_b = stop;
        @(negedge clk); start_b = 1'b0; stop_b = !stop;
        check("B_busy_after_start", 32'(busy_b), 1);
        wait_done(1'b1, "B");
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [1:0] f [0:7];
        int i;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("A_rst_pi", 32'(pi_a), 0);
        check("A_rst_busy", 32'(busy_a), 0);
        check("A_rst_done", 32'(done_a), 0);
        check("A_rst_mismatch", 32'(mis_a), 0);
        check("A_rst_fail_pattern", 32'(fp_a), 0);
        check("A_rst_fail_mask", 32'(fm_a), 0);
        check("A_rst_count", 32'(cnt_a), 0);
        check("B_rst_done", 32'(done_b), 0);

        f = '{default: 2'b00};
        run_a(f, 1'b0, 0);                          // equivalent circuits
        f[5] = 2'b10;
        run_a(f, 1'b0, 0);                          // single fault at pattern 5
        f = '{default: 2'b00}; f[3] = 2'b01; f[6] = 2'b11;
        run_a(f, 1'b1, 0);                          // early stop at pattern 3
        run_a(f, 1'b0, 0);                          // same faults, full sweep
        run_a(f, 1'b0, 4);                          // start pulsed at cycle 5 is ignored

        run_b(1'b0, 1'b0);                          // matching latency, 32 busy cycles
        run_b(1'b1, 1'b0);                          // late implementation mismatches
        run_b(1'b1, 1'b1);
        run_b(1'b0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            bit stop;
            int poke;
            for (int p = 0; p < 8; p++)
                f[p] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            stop = 1'($urandom_range(0, 1));
            poke = (!stop && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0;
            run_a(f, stop, poke);
        end

        // Reset in the middle of pattern 4 after a mismatch has already been recorded.
        f = '{default: 2'b00}; f[1] = 2'b01;
        fault_a = f;
        @(negedge clk); start_a = 1'b1; stop_a = 1'b0;
        @(negedge clk); start_a = 1'b0;
        i = 0;
        while (pi_a != 3'd4 && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("A_reached_pattern4", 32'(pi_a), 4);
        check("A_mismatch_before_rst", 32'(mis_a), 1);
        rst = 1'b1;
        @(negedge clk);
        check("A_midrst_pi", 32'(pi_a), 0);
        check("A_midrst_busy", 32'(busy_a), 0);
        check("A_midrst_done", 32'(done_a), 0);
        check("A_midrst_mismatch", 32'(mis_a), 0);
        check("A_midrst_fail_pattern", 32'(fp_a), 0);
        check("A_midrst_fail_mask", 32'(fm_a), 0);
        check("A_midrst_count", 32'(cnt_a), 0);
        start_a = 1'b1;                              // reset wins over start on the same edge
        @(negedge clk);
        rst = 1'b0; start_a = 1'b0;
        check("A_rst_overrides_start", 32'(busy_a), 0);
        last_pi_b = 3'd0;
        repeat (5) @(negedge clk);
        f = '{default: 2'b00}; f[0] = 2'b11;
        run_a(f, 1'b0, 0);
        run_b(1'b1, 1'b0);

        check("A_queue_empty", 32'(q_a.size()), 0);
        check("B_queue_empty", 32'(q_b.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
